// File: rtl/ae_pkg.sv
// ae_pkg: OV5640 AEC register map, sequence sizing and FSM states for the AE sensor writer.
// Sequence length depends on AE_GROUP_HOLD_EN (group-hold wrapper around the AEC writes).
package ae_pkg;
  localparam logic [15:0] REG_EXP_H  = 16'h3500;
  localparam logic [15:0] REG_EXP_M  = 16'h3501;
  localparam logic [15:0] REG_EXP_L  = 16'h3502;
  localparam logic [15:0] REG_GAIN_H = 16'h350A;
  localparam logic [15:0] REG_GAIN_L = 16'h350B;
  localparam logic [15:0] REG_GROUP  = 16'h3212;
  localparam logic [7:0] GRP_START  = 8'h00;
  localparam logic [7:0] GRP_END    = 8'h10;
  localparam logic [7:0] GRP_LAUNCH = 8'hA0;
`ifdef AE_GROUP_HOLD_EN
  localparam int SEQ_LEN = 8;
  localparam logic [2:0] SEQ_OFS = 3'd1;
`else
  localparam int SEQ_LEN = 5;
  localparam logic [2:0] SEQ_OFS = 3'd0;
`endif
  localparam logic [2:0] LAST_IDX = 3'(SEQ_LEN - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
endpackage

// File: rtl/ae_sensor_reg_writer_if.sv
// ae_sensor_reg_writer_if: valid/ready register-write command port toward the SCCB master.
interface ae_sensor_reg_writer_if;
  logic        valid;
  logic        ready;
  logic [15:0] addr;
  logic [7:0]  data;
  modport master (output valid, addr, data, input ready);
  modport slave (input valid, addr, data, output ready);
endinterface

// File: rtl/ae_reg_seq_rom.sv
// ae_reg_seq_rom: maps burst index and snapshot exposure/gain to one sensor register write.
module ae_reg_seq_rom
  import ae_pkg::*;
(
  input  logic [2:0]  index,
  input  logic [15:0] e_snap,
  input  logic [9:0]  g_snap,
  output logic [15:0] addr,
  output logic [7:0]  data,
  output logic        last_entry
);
  logic [2:0] j;
  always_comb begin
    j = index - SEQ_OFS;
    addr = REG_GROUP;
    data = index == LAST_IDX ? GRP_LAUNCH : j == 3'd5 ? GRP_END : GRP_START;
    case (j)
      3'd0: begin addr = REG_EXP_H;  data = {4'h0, e_snap[15:12]}; end
      3'd1: begin addr = REG_EXP_M;  data = e_snap[11:4]; end
      3'd2: begin addr = REG_EXP_L;  data = {e_snap[3:0], 4'h0}; end
      3'd3: begin addr = REG_GAIN_H; data = {6'b0, g_snap[9:8]}; end
      3'd4: begin addr = REG_GAIN_L; data = g_snap[7:0]; end
      default: ;
    endcase
    last_entry = index == LAST_IDX;
  end
endmodule

// File: rtl/ae_sensor_reg_writer.sv
// ae_sensor_reg_writer: clamps AE results and writes them to the sensor on the next frame boundary.
// Optional macro AE_GROUP_HOLD_EN wraps the burst in an OV5640 group-hold sequence.
module ae_sensor_reg_writer
  import ae_pkg::*;
#(
  parameter logic [15:0] EXP_MIN  = 16'd1,
  parameter logic [15:0] EXP_MAX  = 16'd1964,
  parameter logic [15:0] GAIN_MIN = 16'h0010,
  parameter logic [15:0] GAIN_MAX = 16'h03FF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ae_valid,
  input  logic [15:0]                   exposure_time,
  input  logic [15:0]                   exposure_gain,
  input  logic                          frame_vsync,
  ae_sensor_reg_writer_if.master        cmd,
  output logic                          busy,
  output logic                          update_done,
  output logic [15:0]                   applied_exposure,
  output logic [15:0]                   applied_gain
);
  state_t      state, state_n;
  logic        vsync_d, pending, vs_rise, differ, launch, hs, last;
  logic [15:0] e_in, g_in, pend_e, pend_g, e_snap, g_snap, rom_addr;
  logic [7:0]  rom_data;
  logic [2:0]  index;
  ae_reg_seq_rom u_rom (
    .index      (index),
    .e_snap     (e_snap),
    .g_snap     (g_snap[9:0]),
    .addr       (rom_addr),
    .data       (rom_data),
    .last_entry (last)
  );
  // A same-cycle ae_valid supersedes pending, including an equal value that cancels it.
  always_comb begin
    e_in = exposure_time < EXP_MIN ? EXP_MIN : exposure_time > EXP_MAX ? EXP_MAX : exposure_time;
    g_in = exposure_gain < GAIN_MIN ? GAIN_MIN : exposure_gain > GAIN_MAX ? GAIN_MAX : exposure_gain;
    differ = {e_in, g_in} != {applied_exposure, applied_gain};
    vs_rise = frame_vsync & ~vsync_d;
    launch = state == IDLE && vs_rise && (ae_valid ? differ : pending);
    hs = cmd.valid & cmd.ready;
    state_n = state == IDLE ? (launch ? ISSUE : IDLE) : state == ISSUE ? (hs && last ? DONE : ISSUE) : IDLE;
  end
  assign cmd.valid   = state == ISSUE;
  assign cmd.addr    = cmd.valid ? rom_addr : 16'h0;
  assign cmd.data    = cmd.valid ? rom_data : 8'h0;
  assign busy        = state == ISSUE;
  assign update_done = state == DONE;
  // applied_* load on the final handshake so they are valid alongside update_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vsync_d <= 1'b1;
      pending <= 1'b0;
      pend_e <= '0;
      pend_g <= '0;
      e_snap <= '0;
      g_snap <= '0;
      index <= '0;
      applied_exposure <= '0;
      applied_gain <= '0;
    end else begin
      state <= state_n;
      vsync_d <= frame_vsync;
      if (launch) begin
        pending <= 1'b0;
        e_snap <= ae_valid ? e_in : pend_e;
        g_snap <= ae_valid ? g_in : pend_g;
        index <= '0;
      end else if (ae_valid) begin
        pending <= differ;
        pend_e <= e_in;
        pend_g <= g_in;
      end
      if (hs) index <= index + 3'd1;
      if (hs && last) begin
        applied_exposure <= e_snap;
        applied_gain <= g_snap;
      end
    end
  end
endmodule

// File: tb/tb_ae_sensor_reg_writer.sv
// tb_ae_sensor_reg_writer: scoreboard bench for ae_sensor_reg_writer (honours AE_GROUP_HOLD_EN).
module tb_ae_sensor_reg_writer;
  logic        clk = 0, rst = 1, ae_valid = 0, frame_vsync = 0;
  logic [15:0] exposure_time = 0, exposure_gain = 0, applied_exposure, applied_gain;
  logic        busy, update_done;
  int n_cmp = 0, n_err = 0, done_cnt = 0;
  logic [23:0] exp_q[$];
  logic [31:0] app_q[$];
`ifdef AE_GROUP_HOLD_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  ae_sensor_reg_writer_if cmd ();
  ae_sensor_reg_writer dut (
    .clk              (clk),
    .rst              (rst),
    .ae_valid         (ae_valid),
    .exposure_time    (exposure_time),
    .exposure_gain    (exposure_gain),
    .frame_vsync      (frame_vsync),
    .cmd              (cmd),
    .busy             (busy),
    .update_done      (update_done),
    .applied_exposure (applied_exposure),
    .applied_gain     (applied_gain)
  );
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected writes carry hand-computed data bytes for the five AEC registers.
  task automatic expect_burst(input logic [7:0] d0, d1, d2, d3, d4, input logic [15:0] e, g);
`ifdef AE_GROUP_HOLD_EN
    exp_q.push_back({16'h3212, 8'h00});
`endif
    exp_q.push_back({16'h3500, d0});
    exp_q.push_back({16'h3501, d1});
    exp_q.push_back({16'h3502, d2});
    exp_q.push_back({16'h350A, d3});
    exp_q.push_back({16'h350B, d4});
`ifdef AE_GROUP_HOLD_EN
    exp_q.push_back({16'h3212, 8'h10});
    exp_q.push_back({16'h3212, 8'hA0});
`endif
    app_q.push_back({e, g});
  endtask

  task automatic ae(input logic [15:0] e, g);
    @(posedge clk); #1;
    ae_valid = 1; exposure_time = e; exposure_gain = g;
    @(posedge clk); #1;
    ae_valid = 0;
  endtask

  task automatic vsync(input logic launch);
    @(posedge clk); #1;
    frame_vsync = 1;
    check("pre_launch_valid", {31'b0, cmd.valid}, 0);
    @(posedge clk); #1;
    frame_vsync = 0;
    check("launch_valid", {31'b0, cmd.valid}, {31'b0, launch});
    check("launch_busy", {31'b0, busy}, {31'b0, launch});
  endtask

  task automatic wait_done(input int budget);
    int start, n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == start) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no update_done within %0d cycles", budget);
    end
    @(posedge clk); #1;
    check("done_one_cycle", {31'b0, update_done}, 0);
    check("idle_busy", {31'b0, busy}, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd.valid && cmd.ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got %h/%h expected none", cmd.addr, cmd.data);
        end else begin
          logic [23:0] w;
          w = exp_q.pop_front();
          check("write", {8'h0, cmd.addr, cmd.data}, {8'h0, w});
        end
      end
      if (update_done) begin
        done_cnt++;
        if (app_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got %h/%h expected none", applied_exposure, applied_gain);
        end else begin
          logic [31:0] a;
          a = app_q.pop_front();
          check("applied", {applied_exposure, applied_gain}, a);
        end
      end
    end
  end

  initial begin
    cmd.ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_valid", {31'b0, cmd.valid}, 0);
    check("rst_addr_data", {8'h0, cmd.addr, cmd.data}, 0);
    check("rst_busy_done", {30'b0, busy, update_done}, 0);
    check("rst_applied", {applied_exposure, applied_gain}, 0);
    // Basic update
    ae(16'h0123, 16'h0040);
    expect_burst(8'h00, 8'h12, 8'h30, 8'h00, 8'h40, 16'h0123, 16'h0040);
    vsync(1);
    wait_done(40);
    // Clamping: e -> 1, g -> 0x3FF
    ae(16'h0000, 16'h0800);
    expect_burst(8'h00, 8'h00, 8'h10, 8'h03, 8'hFF, 16'h0001, 16'h03FF);
    vsync(1);
    wait_done(40);
    // Upper exposure clamp to 1964 (0x07AC), lower gain clamp to 0x10
    ae(16'hFFFF, 16'h0001);
    expect_burst(8'h00, 8'h7A, 8'hC0, 8'h00, 8'h10, 16'h07AC, 16'h0010);
    vsync(1);
    wait_done(40);
    // Backpressure on the 0x3502 entry
    ae(16'h07AC, 16'h0155);
    expect_burst(8'h00, 8'h7A, 8'hC0, 8'h01, 8'h55, 16'h07AC, 16'h0155);
    vsync(1);
    repeat (OFS + 2) @(posedge clk);
    #1 cmd.ready = 0;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_addr_data", {8'h0, cmd.addr, cmd.data}, {8'h0, 16'h3502, 8'hC0});
      check("bp_busy", {31'b0, busy}, 1);
    end
    cmd.ready = 1;
    wait_done(40);
    // Redundant value: no burst
    ae(16'h07AC, 16'h0155);
    vsync(0);
    repeat (4) @(posedge clk);
    #1 check("redundant_busy", {31'b0, busy}, 0);
    // Overwrite before vsync: only the later value is written
    ae(16'h0100, 16'h0040);
    ae(16'h0200, 16'h0040);
    expect_burst(8'h00, 8'h20, 8'h00, 8'h00, 8'h40, 16'h0200, 16'h0040);
    vsync(1);
    wait_done(40);
    // Reset mid-burst at index 3
    ae(16'h0050, 16'h0020);
    expect_burst(8'h00, 8'h05, 8'h00, 8'h00, 8'h20, 16'h0050, 16'h0020);
    vsync(1);
    repeat (3) @(posedge clk);
    #1 cmd.ready = 0;
    rst = 1;
    @(posedge clk); #1;
    check("midrst_valid", {31'b0, cmd.valid}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_applied", {applied_exposure, applied_gain}, 0);
    exp_q.delete();
    app_q.delete();
    rst = 0;
    cmd.ready = 1;
    ae(16'h0050, 16'h0020);
    expect_burst(8'h00, 8'h05, 8'h00, 8'h00, 8'h20, 16'h0050, 16'h0020);
    vsync(1);
    wait_done(40);
    check("writes_drained", exp_q.size(), 0);
    check("dones_drained", app_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
